pcie_link_activity_monitor: RTL and testbench

Synthesisable, parametrised PCIe link monitor that replaces the behavioural single-width PLI monitor in regressions needing cycle-accurate link status without a simulator callback. It samples the differential TX/RX lane pairs of an N-lane link on one monitor clock and tracks per-lane electrical activity. A link state machine reports negotiated width, degraded-width operation and a saturating link-down event count. It sits passively on the serial lanes beside the PCIe BFM and drives only status outputs.

---
 rtl/pcie_link_activity_monitor.sv | 183 ++++++++++++++++++
 tb/tb_pcie_link_activity_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_link_activity_monitor.sv
// Passive PCIe lane monitor: synchronises the serial pairs, tracks per-lane
// electrical activity, link state, negotiated width and link-down events.
module pcie_link_activity_monitor #(
  parameter int LINK_WIDTH  = 1,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PERST_n,
  input  logic [LINK_WIDTH-1:0] TX,
  input  logic [LINK_WIDTH-1:0] TX_,
  input  logic [LINK_WIDTH-1:0] RX,
  input  logic [LINK_WIDTH-1:0] RX_,
  input  logic                  CLR_CNT,
  output logic [LINK_WIDTH-1:0] TX_ACTIVE,
  output logic [LINK_WIDTH-1:0] RX_ACTIVE,
  output logic [2:0]            LINK_STATE,
  output logic [5:0]            ACTIVE_WIDTH,
  output logic                  DEGRADED,
  output logic [CNT_WIDTH-1:0]  LINKDOWN_CNT
);

  localparam int IW  = $clog2(IDLE_CYCLES + 1);
  localparam int NCH = 2 * LINK_WIDTH;
  localparam int SW  = 2 * NCH + 1;
  localparam logic [IW-1:0]        IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_DETECT   = 3'd1,
    ST_TRAIN    = 3'd2,
    ST_LINKUP   = 3'd3,
    ST_ELECIDLE = 3'd4
  } state_t;

  logic [SW-1:0]         sync1_reg, sync2_reg;
  logic                  perst_n_sync;
  logic [NCH-1:0]        pair_p, pair_n;
  logic [NCH-1:0]        act_mask, act_mask_next;
  logic [LINK_WIDTH-1:0] tx_mask, rx_mask, tx_mask_next, rx_mask_next;
  logic [LINK_WIDTH-1:0] tx_prev_reg, rx_prev_reg;
  logic [IW-1:0]         stab_reg, stab_next;
  logic                  masks_zero, masks_changed, masks_stable;
  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [5:0]            width_reg, width_next;
  logic                  degraded_reg, degraded_next;
  logic                  linkdown_event;

  // Two-flop synchroniser for PERST_n and every lane wire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {PERST_n, RX_, TX_, RX, TX};
      sync2_reg <= sync1_reg;
    end
  end

  // Channels [LINK_WIDTH-1:0] are TX lanes, the upper half are RX lanes.
  assign pair_p       = sync2_reg[NCH-1:0];
  assign pair_n       = sync2_reg[2*NCH-1:NCH];
  assign perst_n_sync = sync2_reg[SW-1];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic [IW-1:0] idle_reg, idle_next;
      logic          chan_act_reg, chan_act_next;

      always_comb begin
        idle_next     = idle_reg;
        chan_act_next = chan_act_reg;
        if (pair_p[gi] != pair_n[gi]) begin
          idle_next     = '0;
          chan_act_next = 1'b1;
        end else if (idle_reg != IDLE_MAX) begin
          idle_next = idle_reg + 1'b1;
          if (idle_next == IDLE_MAX) chan_act_next = 1'b0;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          idle_reg     <= IDLE_MAX;
          chan_act_reg <= 1'b0;
        end else begin
          idle_reg     <= idle_next;
          chan_act_reg <= chan_act_next;
        end
      end

      assign act_mask[gi]      = chan_act_reg;
      assign act_mask_next[gi] = chan_act_next;
    end
  endgenerate

  assign tx_mask      = act_mask[LINK_WIDTH-1:0];
  assign rx_mask      = act_mask[NCH-1:LINK_WIDTH];
  assign tx_mask_next = act_mask_next[LINK_WIDTH-1:0];
  assign rx_mask_next = act_mask_next[NCH-1:LINK_WIDTH];

  assign masks_zero    = (tx_mask == '0) && (rx_mask == '0);
  assign masks_changed = (tx_mask != tx_prev_reg) || (rx_mask != rx_prev_reg);
  assign masks_stable  = (tx_mask == rx_mask) && !masks_zero && !masks_changed;

  always_comb begin
    stab_next = '0;
    if (masks_stable) stab_next = (stab_reg == IDLE_MAX) ? IDLE_MAX : stab_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    if (!perst_n_sync) begin
      state_next = ST_RESET;
    end else begin
      case (state_reg)
        ST_RESET:    state_next = ST_DETECT;
        ST_DETECT:   if (!masks_zero) state_next = ST_TRAIN;
        ST_TRAIN: begin
          if (stab_reg == IDLE_MAX) state_next = ST_LINKUP;
          else if (masks_zero)      state_next = ST_DETECT;
        end
        ST_LINKUP: begin
          if (masks_zero)         state_next = ST_ELECIDLE;
          else if (masks_changed) state_next = ST_TRAIN;
        end
        ST_ELECIDLE: if (!masks_zero) state_next = ST_TRAIN;
        default:     state_next = ST_RESET;
      endcase
    end
  end

  // Width is taken from the masks that will be visible alongside the new state.
  always_comb begin
    width_next = '0;
    for (int i = 0; i < LINK_WIDTH; i++) begin
      width_next = width_next + 6'(tx_mask_next[i] & rx_mask_next[i]);
    end
    if (state_next != ST_LINKUP) width_next = '0;
    degraded_next = (state_next == ST_LINKUP) && (32'(width_next) < LINK_WIDTH);
  end

  assign linkdown_event = (state_reg == ST_LINKUP) &&
                          ((state_next == ST_ELECIDLE) || (state_next == ST_RESET));

  always_comb begin
    cnt_next = cnt_reg;
    if (CLR_CNT)                                    cnt_next = '0;
    else if (linkdown_event && (cnt_reg != CNT_MAX)) cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_RESET;
      stab_reg     <= '0;
      tx_prev_reg  <= '0;
      rx_prev_reg  <= '0;
      cnt_reg      <= '0;
      width_reg    <= '0;
      degraded_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      stab_reg     <= stab_next;
      tx_prev_reg  <= tx_mask;
      rx_prev_reg  <= rx_mask;
      cnt_reg      <= cnt_next;
      width_reg    <= width_next;
      degraded_reg <= degraded_next;
    end
  end

  assign TX_ACTIVE    = tx_mask;
  assign RX_ACTIVE    = rx_mask;
  assign LINK_STATE   = state_reg;
  assign ACTIVE_WIDTH = width_reg;
  assign DEGRADED     = degraded_reg;
  assign LINKDOWN_CNT = cnt_reg;

endmodule

// File: tb/tb_pcie_link_activity_monitor.sv
// Self-checking bench: random lane toggling against a behavioural link model,
// plus directed checks of the link-up, degrade, link-down and reset scenarios.
module tb_pcie_link_activity_monitor;

  localparam int LW   = 4;
  localparam int IDLE = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, perst_n, clr;
  logic [LW-1:0] tx_p, tx_n, rx_p, rx_n;
  logic [LW-1:0] tx_active, rx_active;
  logic [2:0]    link_state;
  logic [5:0]    active_width;
  logic          degraded;
  logic [CW-1:0] linkdown_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcie_link_activity_monitor #(.LINK_WIDTH(LW), .IDLE_CYCLES(IDLE), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RST(rst), .PERST_n(perst_n),
    .TX(tx_p), .TX_(tx_n), .RX(rx_p), .RX_(rx_n),
    .CLR_CNT(clr),
    .TX_ACTIVE(tx_active), .RX_ACTIVE(rx_active), .LINK_STATE(link_state),
    .ACTIVE_WIDTH(active_width), .DEGRADED(degraded), .LINKDOWN_CNT(linkdown_cnt)
  );

  // Behavioural model: lane activity is "fewer than IDLE samples since the
  // last unequal pair"; the link state follows the transition rules directly.
  logic [LW-1:0] q1_tp, q1_tn, q1_rp, q1_rn, q2_tp, q2_tn, q2_rp, q2_rn;
  logic          q1_pr, q2_pr;
  int            age_t[LW], age_r[LW];
  int            run_len, r_state, r_cnt;
  logic [LW-1:0] r_tx, r_rx, r_txp, r_rxp;

  task automatic model_reset();
    q1_tp = '0; q1_tn = '0; q1_rp = '0; q1_rn = '0;
    q2_tp = '0; q2_tn = '0; q2_rp = '0; q2_rn = '0;
    q1_pr = 1'b0; q2_pr = 1'b0;
    for (int l = 0; l < LW; l++) begin
      age_t[l] = IDLE;
      age_r[l] = IDLE;
    end
    run_len = 0; r_state = 0; r_cnt = 0;
    r_tx = '0; r_rx = '0; r_txp = '0; r_rxp = '0;
  endtask

  task automatic model_edge();
    int            ns;
    bit            zero, chg;
    logic [LW-1:0] ntx, nrx;
    if (rst) begin
      model_reset();
    end else begin
      zero = (r_tx == 0) && (r_rx == 0);
      chg  = (r_tx != r_txp) || (r_rx != r_rxp);
      ns   = r_state;
      if (!q2_pr) ns = 0;
      else begin
        case (r_state)
          0: ns = 1;
          1: ns = zero ? 1 : 2;
          2: ns = (run_len >= IDLE) ? 3 : (zero ? 1 : 2);
          3: ns = zero ? 4 : (chg ? 2 : 3);
          4: ns = zero ? 4 : 2;
          default: ns = 0;
        endcase
      end
      for (int l = 0; l < LW; l++) begin
        if (q2_tp[l] != q2_tn[l]) age_t[l] = 0; else if (age_t[l] < IDLE) age_t[l]++;
        if (q2_rp[l] != q2_rn[l]) age_r[l] = 0; else if (age_r[l] < IDLE) age_r[l]++;
        ntx[l] = (age_t[l] < IDLE);
        nrx[l] = (age_r[l] < IDLE);
      end
      if (r_tx == r_rx && !zero && !chg) run_len = (run_len < IDLE) ? run_len + 1 : IDLE;
      else run_len = 0;
      if (clr) r_cnt = 0;
      else if (r_state == 3 && (ns == 4 || ns == 0) && r_cnt < CMAX) r_cnt++;
      r_txp = r_tx; r_rxp = r_rx;
      r_tx = ntx;   r_rx = nrx;
      r_state = ns;
      q2_tp = q1_tp; q2_tn = q1_tn; q2_rp = q1_rp; q2_rn = q1_rn; q2_pr = q1_pr;
      q1_tp = tx_p;  q1_tn = tx_n;  q1_rp = rx_p;  q1_rn = rx_n;  q1_pr = perst_n;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    int exp_w;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_w = (r_state == 3) ? $countones(r_tx & r_rx) : 0;
    chk("tx_active",    32'(tx_active),    32'(r_tx));
    chk("rx_active",    32'(rx_active),    32'(r_rx));
    chk("link_state",   32'(link_state),   32'(r_state));
    chk("active_width", 32'(active_width), 32'(exp_w));
    chk("degraded",     32'(degraded),     32'((r_state == 3) && (exp_w < LW)));
    chk("linkdown_cnt", 32'(linkdown_cnt), 32'(r_cnt));
  endtask

  // Enabled lanes drive unequal pairs (occasionally equal if eq_ok); others equal.
  task automatic drive(input logic [LW-1:0] te, input logic [LW-1:0] re, input bit eq_ok);
    logic p;
    for (int l = 0; l < LW; l++) begin
      p = 1'($urandom);
      tx_p[l] = p;
      tx_n[l] = (te[l] && !(eq_ok && ($urandom % 8 == 0))) ? ~p : p;
      p = 1'($urandom);
      rx_p[l] = p;
      rx_n[l] = (re[l] && !(eq_ok && ($urandom % 8 == 0))) ? ~p : p;
    end
  endtask

  // The final step of every run drives all enabled lanes unequal so that a
  // following all-idle phase drops every mask on the same edge.
  task automatic run(input logic [LW-1:0] te, input logic [LW-1:0] re, input int n, input bit eq_ok);
    for (int i = 0; i < n; i++) begin
      drive(te, re, eq_ok && (i != n - 1));
      step();
    end
  endtask

  initial begin
    bit fired;
    rst = 1'b1; perst_n = 1'b0; clr = 1'b0;
    tx_p = '0; tx_n = '0; rx_p = '0; rx_n = '0;
    model_reset();

    run(4'h0, 4'h0, 3, 0);
    chk("reset_state", 32'(link_state), 32'd0);
    chk("reset_cnt", 32'(linkdown_cnt), 32'd0);
    chk("reset_masks", 32'({tx_active, rx_active}), 32'd0);

    rst = 1'b0; perst_n = 1'b1;
    run(4'h0, 4'h0, 5, 0);
    chk("detect_state", 32'(link_state), 32'd1);

    run(4'hF, 4'hF, 60, 1);
    chk("linkup_state", 32'(link_state), 32'd3);
    chk("linkup_width", 32'(active_width), 32'd4);
    chk("linkup_degraded", 32'(degraded), 32'd0);

    run(4'h7, 4'hF, 40, 1);
    chk("lane3_tx_mask", 32'(tx_active), 32'h7);
    chk("lane3_rx_mask", 32'(rx_active), 32'hF);
    chk("lane3_state", 32'(link_state), 32'd2);

    run(4'h3, 4'h3, 60, 1);
    chk("degraded_state", 32'(link_state), 32'd3);
    chk("degraded_width", 32'(active_width), 32'd2);
    chk("degraded_flag", 32'(degraded), 32'd1);

    run(4'h0, 4'h0, 40, 0);
    chk("elecidle_state", 32'(link_state), 32'd4);
    chk("elecidle_cnt", 32'(linkdown_cnt), 32'd1);
    run(4'hF, 4'hF, 60, 1);
    chk("relink_state", 32'(link_state), 32'd3);

    for (int k = 2; k <= 5; k++) begin
      run(4'h0, 4'h0, 40, 0);
      chk("sat_cnt", 32'(linkdown_cnt), 32'((k < CMAX) ? k : CMAX));
      run(4'hF, 4'hF, 60, 1);
    end

    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      clr = (r_state == 3 && r_tx == 0 && r_rx == 0);
      fired = clr;
      drive(4'h0, 4'h0, 0);
      step();
      clr = 1'b0;
    end
    chk("clr_event_seen", 32'(fired), 32'd1);
    chk("clr_wins_cnt", 32'(linkdown_cnt), 32'd0);
    chk("clr_wins_state", 32'(link_state), 32'd4);

    run(4'hF, 4'hF, 60, 1);
    perst_n = 1'b0;
    run(4'hF, 4'hF, 2, 0);
    chk("perst_edge2_state", 32'(link_state), 32'd3);
    run(4'hF, 4'hF, 1, 0);
    chk("perst_edge3_state", 32'(link_state), 32'd0);
    chk("perst_cnt", 32'(linkdown_cnt), 32'd1);
    perst_n = 1'b1;
    run(4'hF, 4'hF, 40, 1);
    chk("perst_relink", 32'(link_state), 32'd3);

    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      drive(4'h7, 4'hF, 1);
      step();
      fired = (link_state == 3'd2);
    end
    chk("train_reached", 32'(fired), 32'd1);
    rst = 1'b1;
    run(4'h7, 4'hF, 1, 0);
    chk("rst_mid_outputs", 32'({tx_active, rx_active, link_state, active_width, degraded, linkdown_cnt}), 32'd0);
    rst = 1'b0;

    for (int s = 0; s < 12; s++) begin
      perst_n = ($urandom % 6 != 0);
      run(4'($urandom), 4'($urandom), 30, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
